// File: rtl/periph_xbar_tracked.sv
// Peripheral crossbar with a runtime rule-based address map, per-input
// outstanding-transaction tracking (in-order responses) and a built-in error slave.
module periph_xbar_tracked #(
  parameter int NumInp    = 9,
  parameter int NumOup    = 10,
  parameter int NumRules  = 8,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int BeWidth   = 4,
  parameter int MaxTxn    = 4,
  parameter logic [DataWidth-1:0] ErrData = DataWidth'(32'hBADACCE5),
  parameter int IdWidth   = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumInp-1:0]                       inp_req_i,
  output logic [NumInp-1:0]                       inp_gnt_o,
  input  logic [NumInp-1:0][AddrWidth-1:0]        inp_add_i,
  input  logic [NumInp-1:0]                       inp_wen_i,
  input  logic [NumInp-1:0][DataWidth-1:0]        inp_wdata_i,
  input  logic [NumInp-1:0][BeWidth-1:0]          inp_be_i,
  output logic [NumInp-1:0]                       inp_r_valid_o,
  output logic [NumInp-1:0][DataWidth-1:0]        inp_r_rdata_o,
  output logic [NumInp-1:0]                       inp_r_opc_o,
  output logic [NumOup-1:0]                       oup_req_o,
  input  logic [NumOup-1:0]                       oup_gnt_i,
  output logic [NumOup-1:0][AddrWidth-1:0]        oup_add_o,
  output logic [NumOup-1:0]                       oup_wen_o,
  output logic [NumOup-1:0][DataWidth-1:0]        oup_wdata_o,
  output logic [NumOup-1:0][BeWidth-1:0]          oup_be_o,
  output logic [NumOup-1:0][IdWidth-1:0]          oup_id_o,
  input  logic [NumOup-1:0]                       oup_r_valid_i,
  input  logic [NumOup-1:0][IdWidth-1:0]          oup_r_id_i,
  input  logic [NumOup-1:0][DataWidth-1:0]        oup_r_rdata_i,
  input  logic [NumOup-1:0]                       oup_r_opc_i,
  input  logic [NumRules-1:0][AddrWidth-1:0]      rule_base_i,
  input  logic [NumRules-1:0][AddrWidth-1:0]      rule_mask_i,
  input  logic [NumRules-1:0][$clog2(NumOup+1)-1:0] rule_idx_i,
  input  logic [$clog2(NumOup+1)-1:0]             default_idx_i
);

  // Handshake: a request transfers in any cycle where req and gnt are both
  // high; a response is a single-cycle r_valid pulse with no back-pressure.

  localparam int TgtWidth = $clog2(NumOup+1);
  localparam int CntWidth = $clog2(MaxTxn+1);
  localparam logic [TgtWidth-1:0] ErrTgt = TgtWidth'(NumOup);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxn);
  localparam logic [IdWidth-1:0]  LastId = IdWidth'(NumInp-1);

  logic [NumInp-1:0][TgtWidth-1:0] tgt;
  logic [NumInp-1:0][TgtWidth-1:0] dst_q;
  logic [NumInp-1:0][CntWidth-1:0] cnt_q;
  logic [NumInp-1:0]               elig;
  logic [NumInp-1:0]               gnt;
  logic [NumInp-1:0]               rsp;
  logic [NumOup:0]                 found;
  logic [NumOup:0]                 port_gnt;
  logic [NumOup:0][IdWidth-1:0]    win;
  logic [NumOup:0][IdWidth-1:0]    ptr_q;
  logic                            err_valid_q;
  logic [IdWidth-1:0]              err_id_q;

  // Out-of-range targets collapse onto one ERR port index (NumOup).
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      tgt[i] = default_idx_i;
      for (int r = NumRules-1; r >= 0; r--) begin
        if ((inp_add_i[i] & rule_mask_i[r]) == (rule_base_i[r] & rule_mask_i[r]))
          tgt[i] = rule_idx_i[r];
      end
      if (tgt[i] >= ErrTgt) tgt[i] = ErrTgt;
      elig[i] = inp_req_i[i] &&
                ((cnt_q[i] == '0) || ((tgt[i] == dst_q[i]) && (cnt_q[i] < CntMax)));
    end
  end

  assign port_gnt = {1'b1, oup_gnt_i};

  always_comb begin
    int idx;
    idx = 0;
    for (int k = 0; k <= NumOup; k++) begin
      found[k] = 1'b0;
      win[k]   = '0;
      for (int off = 0; off < NumInp; off++) begin
        idx = int'(ptr_q[k]) + off;
        if (idx >= NumInp) idx = idx - NumInp;
        if (!found[k] && elig[idx] && (tgt[idx] == TgtWidth'(k))) begin
          found[k] = 1'b1;
          win[k]   = IdWidth'(idx);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      gnt[i] = !rst_i && elig[i] && found[tgt[i]] &&
               (win[tgt[i]] == IdWidth'(i)) && port_gnt[tgt[i]];
    end
  end

  assign inp_gnt_o = gnt;

  always_comb begin
    for (int k = 0; k < NumOup; k++) begin
      oup_req_o[k]   = 1'b0;
      oup_add_o[k]   = '0;
      oup_wen_o[k]   = 1'b0;
      oup_wdata_o[k] = '0;
      oup_be_o[k]    = '0;
      oup_id_o[k]    = '0;
      if (!rst_i && found[k]) begin
        oup_req_o[k]   = 1'b1;
        oup_add_o[k]   = inp_add_i[win[k]];
        oup_wen_o[k]   = inp_wen_i[win[k]];
        oup_wdata_o[k] = inp_wdata_i[win[k]];
        oup_be_o[k]    = inp_be_i[win[k]];
        oup_id_o[k]    = win[k];
      end
    end
  end

  // At most one source per input is active thanks to the single-destination rule.
  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      rsp[i]           = 1'b0;
      inp_r_rdata_o[i] = '0;
      inp_r_opc_o[i]   = 1'b0;
      for (int j = 0; j < NumOup; j++) begin
        if (oup_r_valid_i[j] && (oup_r_id_i[j] == IdWidth'(i))) begin
          rsp[i]           = 1'b1;
          inp_r_rdata_o[i] = oup_r_rdata_i[j];
          inp_r_opc_o[i]   = oup_r_opc_i[j];
        end
      end
      if (err_valid_q && (err_id_q == IdWidth'(i))) begin
        rsp[i]           = 1'b1;
        inp_r_rdata_o[i] = ErrData;
        inp_r_opc_o[i]   = 1'b1;
      end
      if (rst_i) begin
        rsp[i]           = 1'b0;
        inp_r_rdata_o[i] = '0;
        inp_r_opc_o[i]   = 1'b0;
      end
    end
  end

  assign inp_r_valid_o = rsp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      dst_q       <= '0;
      ptr_q       <= '0;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      for (int i = 0; i < NumInp; i++) begin
        if (gnt[i] && !rsp[i])
          cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (!gnt[i] && rsp[i] && (cnt_q[i] != '0))
          cnt_q[i] <= cnt_q[i] - 1'b1;
        if (gnt[i]) dst_q[i] <= tgt[i];
      end
      for (int k = 0; k <= NumOup; k++) begin
        if (found[k] && port_gnt[k])
          ptr_q[k] <= (win[k] == LastId) ? '0 : win[k] + 1'b1;
      end
      err_valid_q <= found[NumOup];
      err_id_q    <= win[NumOup];
    end
  end

endmodule

// File: tb/tb_periph_xbar_tracked.sv
// Bench for periph_xbar_tracked: queue-based transaction model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_periph_xbar_tracked;

  localparam int NI  = 9;
  localparam int NO  = 10;
  localparam int NR  = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int MT  = 4;
  localparam int IDW = 4;
  localparam int TW  = 4;
  localparam logic [DW-1:0] ERR_DATA = 32'hBADACCE5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NI-1:0]               inp_req;
  logic [NI-1:0]               inp_gnt_o;
  logic [NI-1:0][AW-1:0]       inp_add;
  logic [NI-1:0]               inp_wen;
  logic [NI-1:0][DW-1:0]       inp_wdata;
  logic [NI-1:0][BW-1:0]       inp_be;
  logic [NI-1:0]               inp_r_valid_o;
  logic [NI-1:0][DW-1:0]       inp_r_rdata_o;
  logic [NI-1:0]               inp_r_opc_o;
  logic [NO-1:0]               oup_req_o;
  logic [NO-1:0]               oup_gnt;
  logic [NO-1:0][AW-1:0]       oup_add_o;
  logic [NO-1:0]               oup_wen_o;
  logic [NO-1:0][DW-1:0]       oup_wdata_o;
  logic [NO-1:0][BW-1:0]       oup_be_o;
  logic [NO-1:0][IDW-1:0]      oup_id_o;
  logic [NO-1:0]               oup_r_valid;
  logic [NO-1:0][IDW-1:0]      oup_r_id;
  logic [NO-1:0][DW-1:0]       oup_r_rdata;
  logic [NO-1:0]               oup_r_opc;
  logic [NR-1:0][AW-1:0]       rule_base;
  logic [NR-1:0][AW-1:0]       rule_mask;
  logic [NR-1:0][TW-1:0]       rule_idx;
  logic [TW-1:0]               default_idx;

  periph_xbar_tracked #(
    .NumInp(NI), .NumOup(NO), .NumRules(NR), .AddrWidth(AW), .DataWidth(DW),
    .BeWidth(BW), .MaxTxn(MT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .inp_req_i(inp_req), .inp_gnt_o(inp_gnt_o), .inp_add_i(inp_add),
    .inp_wen_i(inp_wen), .inp_wdata_i(inp_wdata), .inp_be_i(inp_be),
    .inp_r_valid_o(inp_r_valid_o), .inp_r_rdata_o(inp_r_rdata_o), .inp_r_opc_o(inp_r_opc_o),
    .oup_req_o(oup_req_o), .oup_gnt_i(oup_gnt), .oup_add_o(oup_add_o),
    .oup_wen_o(oup_wen_o), .oup_wdata_o(oup_wdata_o), .oup_be_o(oup_be_o),
    .oup_id_o(oup_id_o), .oup_r_valid_i(oup_r_valid), .oup_r_id_i(oup_r_id),
    .oup_r_rdata_i(oup_r_rdata), .oup_r_opc_i(oup_r_opc),
    .rule_base_i(rule_base), .rule_mask_i(rule_mask), .rule_idx_i(rule_idx),
    .default_idx_i(default_idx)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lowest-index matching rule wins; anything at or beyond NO is the error slave.
  function automatic int decode(input logic [AW-1:0] a);
    for (int r = 0; r < NR; r++) begin
      if ((a & rule_mask[r]) == (rule_base[r] & rule_mask[r]))
        return (int'(rule_idx[r]) >= NO) ? NO : int'(rule_idx[r]);
    end
    return (int'(default_idx) >= NO) ? NO : int'(default_idx);
  endfunction

  // Model: per-input queue of outstanding destinations, per-port next-priority index.
  int outq [NI][$];
  int ptr [NO+1];
  bit errv;
  int errid;

  always @(negedge clk) begin : cmp
    int t [NI];
    int best [NO+1];
    bit eg [NI];
    logic [NI-1:0] egnt, erv, eopc;
    logic [NI-1:0][DW-1:0] erdata;
    logic [NO-1:0] ereq;
    int d, bd;
    bit pg;
    if (rst) begin
      chk("rst_gnt", inp_gnt_o, '0);
      chk("rst_req", oup_req_o, '0);
      chk("rst_rvalid", inp_r_valid_o, '0);
      chk("rst_payload", |{inp_r_rdata_o, inp_r_opc_o, oup_add_o, oup_wen_o,
                           oup_wdata_o, oup_be_o, oup_id_o}, 1'b0);
      for (int i = 0; i < NI; i++) outq[i].delete();
      for (int k = 0; k <= NO; k++) ptr[k] = 0;
      errv  = 1'b0;
      errid = 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        t[i]  = decode(inp_add[i]);
        eg[i] = inp_req[i] &&
                (outq[i].size() == 0 || (outq[i][$] == t[i] && outq[i].size() < MT));
      end
      for (int k = 0; k <= NO; k++) begin
        best[k] = -1;
        bd = NI;
        for (int i = 0; i < NI; i++) begin
          if (eg[i] && t[i] == k) begin
            d = (i - ptr[k] + NI) % NI;
            if (d < bd) begin
              bd = d;
              best[k] = i;
            end
          end
        end
      end
      for (int i = 0; i < NI; i++) begin
        pg = (t[i] == NO) ? 1'b1 : oup_gnt[t[i]];
        egnt[i] = (best[t[i]] == i) && pg;
      end
      for (int k = 0; k < NO; k++) ereq[k] = (best[k] >= 0);
      for (int i = 0; i < NI; i++) begin
        erv[i] = 1'b0;
        erdata[i] = '0;
        eopc[i] = 1'b0;
        for (int j = 0; j < NO; j++) begin
          if (oup_r_valid[j] && int'(oup_r_id[j]) == i) begin
            erv[i] = 1'b1;
            erdata[i] = oup_r_rdata[j];
            eopc[i] = oup_r_opc[j];
          end
        end
        if (errv && errid == i) begin
          erv[i] = 1'b1;
          erdata[i] = ERR_DATA;
          eopc[i] = 1'b1;
        end
      end

      chk("gnt", inp_gnt_o, egnt);
      chk("oup_req", oup_req_o, ereq);
      for (int k = 0; k < NO; k++) begin
        if (ereq[k]) begin
          chk("oup_id", oup_id_o[k], best[k]);
          chk("oup_add", oup_add_o[k], inp_add[best[k]]);
          chk("oup_wen", oup_wen_o[k], inp_wen[best[k]]);
          chk("oup_wdata", oup_wdata_o[k], inp_wdata[best[k]]);
          chk("oup_be", oup_be_o[k], inp_be[best[k]]);
        end
      end
      chk("r_valid", inp_r_valid_o, erv);
      for (int i = 0; i < NI; i++) begin
        if (erv[i]) begin
          chk("r_rdata", inp_r_rdata_o[i], erdata[i]);
          chk("r_opc", inp_r_opc_o[i], eopc[i]);
        end
      end

      for (int i = 0; i < NI; i++) begin
        if (erv[i]) begin
          n_checks++;
          if (outq[i].size() == 0) begin
            n_errors++;
            $display("FAIL proto_rsp input %0d: got response with 0 outstanding, required >=1", i);
          end else begin
            void'(outq[i].pop_front());
          end
        end
        if (egnt[i]) outq[i].push_back(t[i]);
      end
      for (int k = 0; k <= NO; k++) begin
        pg = (k == NO) ? 1'b1 : oup_gnt[k];
        if (best[k] >= 0 && pg) ptr[k] = (best[k] + 1) % NI;
      end
      errv  = (best[NO] >= 0);
      errid = best[NO];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic wen);
    inp_req[i]   = 1'b1;
    inp_add[i]   = a;
    inp_wen[i]   = wen;
    inp_wdata[i] = a ^ 32'h5A5A_0000;
    inp_be[i]    = 4'hF;
  endtask

  task automatic respond(input int j, input int id, input logic [DW-1:0] data);
    oup_r_valid[j] = 1'b1;
    oup_r_id[j]    = IDW'(id);
    oup_r_rdata[j] = data;
    oup_r_opc[j]   = 1'b0;
    step();
    oup_r_valid[j] = 1'b0;
  endtask

  logic [IDW-1:0] exp_q[$];
  logic [IDW-1:0] got;

  initial begin
    rst = 1'b1;
    inp_req = '0; inp_add = '0; inp_wen = '1; inp_wdata = '0; inp_be = '0;
    oup_gnt = '1; oup_r_valid = '0; oup_r_id = '0; oup_r_rdata = '0; oup_r_opc = '0;
    rule_base[0] = 32'h1020_0000; rule_mask[0] = 32'hFFF0_0000; rule_idx[0] = 4'd3;
    rule_base[1] = 32'h1020_0400; rule_mask[1] = 32'hFFFF_FF00; rule_idx[1] = 4'd5;
    rule_base[2] = 32'h2000_0000; rule_mask[2] = 32'hFF00_0000; rule_idx[2] = 4'd2;
    rule_base[3] = 32'h4000_0000; rule_mask[3] = 32'hFF00_0000; rule_idx[3] = 4'd4;
    rule_base[4] = 32'h6000_0000; rule_mask[4] = 32'hFF00_0000; rule_idx[4] = 4'd6;
    rule_base[5] = 32'h7000_0000; rule_mask[5] = 32'hFF00_0000; rule_idx[5] = 4'd12;
    rule_base[6] = 32'h8000_0000; rule_mask[6] = 32'hF000_0000; rule_idx[6] = 4'd1;
    rule_base[7] = 32'hF000_0000; rule_mask[7] = 32'hF000_0000; rule_idx[7] = 4'd7;
    default_idx = 4'd10;

    // Reset with a live request: everything stays quiet.
    step();
    set_req(0, 32'h2000_0000, 1'b1);
    settle();
    chk("reset_gnt", inp_gnt_o, '0);
    chk("reset_oup_req", oup_req_o, '0);
    step();
    rst = 1'b0;
    inp_req[0] = 1'b0;
    step();

    // Rule priority: rules 0 and 1 both match, rule 0 (output 3) wins.
    set_req(4, 32'h1020_0400, 1'b1);
    settle();
    chk("prio_oup_req", oup_req_o, 10'h008);
    chk("prio_oup_id", oup_id_o[3], 4);
    chk("prio_gnt", inp_gnt_o[4], 1'b1);
    step();
    inp_req[4] = 1'b0;
    oup_r_valid[3] = 1'b1; oup_r_id[3] = 4'd4; oup_r_rdata[3] = 32'h1234_5678; oup_r_opc[3] = 1'b0;
    settle();
    chk("prio_rsp_valid", inp_r_valid_o[4], 1'b1);
    chk("prio_rsp_data", inp_r_rdata_o[4], 32'h1234_5678);
    step();
    oup_r_valid[3] = 1'b0;

    // Round robin on output 2: 0,1,2,0 then 1.
    for (int i = 0; i < 3; i++) set_req(i, 32'h2000_0000 + 32'(i * 4), 1'b0);
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    exp_q.push_back(4'd0); exp_q.push_back(4'd1);
    for (int c = 0; c < 5; c++) begin
      settle();
      got = 4'd15;
      for (int i = 0; i < 3; i++) if (inp_gnt_o[i]) got = 4'(i);
      chk("rr_order", got, exp_q.pop_front());
      step();
    end
    inp_req[2:0] = '0;
    respond(2, 0, 32'hA0); respond(2, 0, 32'hA1);
    respond(2, 1, 32'hA2); respond(2, 1, 32'hA3);
    respond(2, 2, 32'hA4);

    // Ordering stall: outstanding to output 4 blocks a request to output 6.
    set_req(0, 32'h4000_0000, 1'b1);
    settle();
    chk("stall_first_gnt", inp_gnt_o[0], 1'b1);
    step();
    inp_add[0] = 32'h6000_0000;
    settle();
    chk("stall_gnt0", inp_gnt_o[0], 1'b0);
    chk("stall_no_req6", oup_req_o[6], 1'b0);
    step();
    oup_r_valid[4] = 1'b1; oup_r_id[4] = 4'd0; oup_r_rdata[4] = 32'hC0DE; oup_r_opc[4] = 1'b0;
    settle();
    chk("stall_gnt_rsp_cycle", inp_gnt_o[0], 1'b0);
    step();
    oup_r_valid[4] = 1'b0;
    settle();
    chk("stall_release", inp_gnt_o[0], 1'b1);
    step();
    inp_req[0] = 1'b0;
    respond(6, 0, 32'hD0);

    // MaxTxn: four grants, fifth stalls; response+handshake keeps the count.
    set_req(5, 32'h4000_0010, 1'b1);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("max_gnt", inp_gnt_o[5], 1'b1);
      step();
    end
    settle();
    chk("max_stall", inp_gnt_o[5], 1'b0);
    oup_r_valid[4] = 1'b1; oup_r_id[4] = 4'd5; oup_r_rdata[4] = 32'hE0; oup_r_opc[4] = 1'b0;
    settle();
    chk("max_stall_rsp", inp_gnt_o[5], 1'b0);
    step();
    settle();
    chk("max_both", inp_gnt_o[5], 1'b1);
    step();
    oup_r_valid[4] = 1'b0;
    settle();
    chk("max_refill", inp_gnt_o[5], 1'b1);
    step();
    settle();
    chk("max_full_again", inp_gnt_o[5], 1'b0);
    inp_req[5] = 1'b0;
    for (int c = 0; c < 4; c++) respond(4, 5, 32'hE1 + 32'(c));

    // Error slave via default index, then via an out-of-range rule index.
    set_req(7, 32'h5000_0000, 1'b1);
    settle();
    chk("err_gnt", inp_gnt_o[7], 1'b1);
    chk("err_no_oup_req", oup_req_o, '0);
    step();
    settle();
    chk("err_rvalid", inp_r_valid_o[7], 1'b1);
    chk("err_rdata", inp_r_rdata_o[7], 32'hBADACCE5);
    chk("err_opc", inp_r_opc_o[7], 1'b1);
    chk("err_gnt_back2back", inp_gnt_o[7], 1'b1);
    step();
    inp_req[7] = 1'b0;
    settle();
    chk("err_rvalid2", inp_r_valid_o[7], 1'b1);
    step();
    settle();
    chk("err_idle", inp_r_valid_o[7], 1'b0);
    set_req(8, 32'h7000_0000, 1'b1);
    settle();
    chk("err_rule_gnt", inp_gnt_o[8], 1'b1);
    step();
    inp_req[8] = 1'b0;
    settle();
    chk("err_rule_rdata", inp_r_rdata_o[8], 32'hBADACCE5);
    step();

    // Reset with two outstanding, then an immediate grant to a new output.
    set_req(3, 32'h2000_0020, 1'b1);
    settle();
    chk("rst_mid_g1", inp_gnt_o[3], 1'b1);
    step();
    settle();
    chk("rst_mid_g2", inp_gnt_o[3], 1'b1);
    step();
    rst = 1'b1;
    settle();
    chk("rst_mid_gnt", inp_gnt_o, '0);
    chk("rst_mid_req", oup_req_o, '0);
    step();
    step();
    rst = 1'b0;
    inp_add[3] = 32'h6000_0000;
    settle();
    chk("rst_mid_new_gnt", inp_gnt_o[3], 1'b1);
    step();
    inp_req[3] = 1'b0;
    respond(6, 3, 32'hF0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/periph_xbar_tracked.md
# periph_xbar_tracked

Parametrised peripheral crossbar that connects `NumInp` request ports (cores plus peripheral masters) to `NumOup` slave peripherals in the cluster peripheral interconnect. It adds three things to the existing peripheral crossbar:
- a runtime-programmable rule-based address map;
- per-input outstanding-transaction tracking that guarantees in-order responses per input;
- a built-in error slave.

Response routing uses binary input IDs instead of one-hot.

## Interface
Parameters:
- `NumInp`, default 9: number of request inputs.
- `NumOup`, default 10: number of peripheral outputs.
- `NumRules`, default 8: number of address-map rules.
- `AddrWidth`, default 32: address width.
- `DataWidth`, default 32: data width.
- `BeWidth`, default 4: byte-enable width.
- `MaxTxn`, default 4: maximum outstanding transactions per input (≥1).
- `ErrData`, default `'hBADACCE5`: read data returned by the error slave, zero-extended or truncated to `DataWidth`.
- `IdWidth`, default `$clog2(NumInp)` (minimum 1): width of the output ID.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous reset, active high.
- `inp_req_i`, `inp_gnt_o`  in/out  `[NumInp]`  request/grant handshake.
- `inp_add_i`  in  `[NumInp][AddrWidth]`  request address.
- `inp_wen_i`  in  `[NumInp]`  write enable, active low.
- `inp_wdata_i`, `inp_be_i`  in  `[NumInp][DataWidth]` / `[NumInp][BeWidth]`  write payload.
- `inp_r_valid_o`, `inp_r_rdata_o`, `inp_r_opc_o`  out  `[NumInp]`, `[NumInp][DataWidth]`, `[NumInp]`  response channel.
- `oup_req_o`, `oup_gnt_i`  out/in  `[NumOup]`  request/grant handshake.
- `oup_add_o`, `oup_wen_o`, `oup_wdata_o`, `oup_be_o`  out  request payload, per output.
- `oup_id_o`  out  `[NumOup][IdWidth]`  binary index of the granted input.
- `oup_r_valid_i`, `oup_r_id_i`, `oup_r_rdata_i`, `oup_r_opc_i`  in  response channel, per output.
- `rule_base_i`, `rule_mask_i`  in  `[NumRules][AddrWidth]`  address-map rules.
- `rule_idx_i`  in  `[NumRules][$clog2(NumOup+1)]`  output index for each rule.
- `default_idx_i`  in  `$clog2(NumOup+1)`  output index when no rule matches.

## Operation
**Decode**
- Rule r matches when `(add & mask_r) == (base_r & mask_r)`. The lowest-index matching rule wins.
- If no rule matches, the target is `default_idx_i`.
- Any target ≥ `NumOup` is routed to the internal error slave (ERR).

**Tracker (per input)**
- State: `cnt` (0..MaxTxn) and `dst` (last target, including ERR).
- An input is eligible when `req` is high and either:
  - `cnt == 0`, or
  - `target == dst` and `cnt < MaxTxn`.
- An ineligible input is stalled: it is not presented to any arbiter and `gnt` stays 0.
- On a request handshake: `cnt++` and `dst <= target`.
- On a response: `cnt--`.
- If both happen in the same cycle, `cnt` is unchanged.
- A response arriving while `cnt == 0` is a protocol violation. The bench asserts on it; the RTL holds `cnt` at 0.

**Arbitration (per output and for ERR)**
- Round-robin among eligible inputs, with priority starting at pointer `p`.
- After a granted handshake, `p <= granted + 1`, wrapping `NumInp-1` to 0. `p` does not move without a handshake.
- The winner's payload drives `oup_*_o`, and `oup_id_o` carries the winner's binary index.
- `inp_gnt_o[i] = winner(i) & oup_gnt_i[target]`.

**Error slave**
- Always grants its round-robin winner.
- One cycle after the grant it returns `r_valid` with `rdata = ErrData` and `opc = 1`, addressed to that input.
- Throughput: 1 transaction per cycle.

**Response routing**
- `inp_r_*[i]` is driven from output j when `oup_r_valid_i[j]` and `oup_r_id_i[j] == i`.
- Because of the single-destination rule, at most one source per input is active in any cycle.

## Timing
- Request path is combinational: input request to `oup_req_o` in 0 cycles, and `oup_gnt_i` to `inp_gnt_o` in 0 cycles.
- Peripheral response path is combinational: `oup_r_*` to `inp_r_*` in 0 cycles.
- Error response latency is exactly 1 cycle after the grant.
- State registers (`cnt`, `dst`, `p`, ERR response register) update on the rising edge of `clk_i`.
- While `rst_i` is high, all outputs are 0: `inp_gnt_o`, `inp_r_valid_o`, `oup_req_o`, and all data, ID and opc outputs.
- At reset: `cnt = 0`, `dst = 0`, `p = 0`, ERR response register invalid.
- Reset mid-transaction drops all outstanding state. Responses from peripherals arriving after reset are ignored for counting: `cnt` saturates at 0.
- The rule inputs are quasi-static. Changing them while any `cnt != 0` is unsupported.

## Test plan
- **Rule priority.** Rules 0 and 1 both match `0x1020_0400` with targets 3 and 5 → request goes to output 3 only; `oup_id_o[3]` equals the input index.
- **Round-robin fairness.** Inputs 0, 1 and 2 hold requests to output 2 with `oup_gnt_i = 1` → grant order 0, 1, 2, 0; `p` returns to 1 after the fourth grant.
- **Ordering stall.** Input 0 has 1 outstanding transaction to output 4 and then requests output 6 → `gnt = 0` until output 4's response; `gnt = 1` in the cycle `cnt` reaches 0.
- **MaxTxn limit.** With `MaxTxn = 4` and no responses → the 5th request stalls. A response and a new handshake in the same cycle leave `cnt = 4`.
- **Error slave.** Address with no matching rule and `default_idx_i = NumOup` → grant in cycle t; in cycle t+1, `r_valid = 1`, `rdata = 0xBADACCE5`, `opc = 1`.
- **Reset mid-operation.** Assert `rst_i` with `cnt = 2` → all outputs 0 during reset; afterwards `cnt = 0` and a new request to a different output is granted immediately.
